// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel deserializer. The output word register sits behind
// a valid/ready handshake and has a sticky overrun flag.
module serial_to_parallel #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             clr_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             empty_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] bit_count_o
);
    typedef enum logic {EMPTY_OUT, FULL_OUT} out_state_t;

    out_state_t       state;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovr_q;
    logic             take;
    logic             done;
    logic [WIDTH-1:0] word_next;

    assign take = valid_i & ~clr_i;
    assign done = take & (cnt_q == CNT_W'(WIDTH - 1));
    // The last bit bypasses the shift register so the word is loaded on the same edge.
    assign word_next = {serial_i, shift_q[WIDTH-2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY_OUT;
            shift_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (clr_i) begin
                shift_q <= '0;
                cnt_q   <= '0;
                ovr_q   <= 1'b0;
            end else if (take) begin
                if (done) begin
                    shift_q <= '0;
                    cnt_q   <= '0;
                end else begin
                    shift_q[cnt_q] <= serial_i;
                    cnt_q          <= cnt_q + CNT_W'(1);
                end
            end

            case (state)
                EMPTY_OUT: begin
                    if (done) begin
                        word_q <= word_next;
                        state  <= FULL_OUT;
                    end
                end
                FULL_OUT: begin
                    // A completion while the consumer stalls drops the new word.
                    if (done) begin
                        if (ready_i) word_q <= word_next;
                        else         ovr_q  <= 1'b1;
                    end else if (ready_i) begin
                        state <= EMPTY_OUT;
                    end
                end
                default: state <= EMPTY_OUT;
            endcase
        end
    end

    assign parallel_o  = word_q;
    assign valid_o     = (state == FULL_OUT);
    assign empty_o     = (cnt_q == '0);
    assign overrun_o   = ovr_q;
    assign bit_count_o = cnt_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed vector table, hand-written reset/clear
// sequences, loopback of random words and a randomized run against a queue model.
module tb_serial_to_parallel;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             serial_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] parallel_o;
    logic             valid_o;
    logic             empty_o;
    logic             overrun_o;
    logic [CNT_W-1:0] bit_count_o;

    int total = 0;
    int bad = 0;

    serial_to_parallel #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
        .clr_i(clr_i), .ready_i(ready_i), .parallel_o(parallel_o),
        .valid_o(valid_o), .empty_o(empty_o), .overrun_o(overrun_o),
        .bit_count_o(bit_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v, s, c, r;
        logic [WIDTH-1:0] par;
        logic             vld, emp, ovr;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    logic [WIDTH-1:0] got[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] par, input logic vld,
                           input logic emp, input logic ovr, input logic [CNT_W-1:0] cnt);
        chk({tag, ".parallel"}, int'(parallel_o), int'(par));
        chk({tag, ".valid"}, int'(valid_o), int'(vld));
        chk({tag, ".empty"}, int'(empty_o), int'(emp));
        chk({tag, ".overrun"}, int'(overrun_o), int'(ovr));
        chk({tag, ".count"}, int'(bit_count_o), int'(cnt));
    endtask

    // Drive inputs on the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic step(input logic v, input logic s, input logic c, input logic r);
        @(negedge clk);
        valid_i = v; serial_i = s; clr_i = c; ready_i = r;
        #1;
        if (valid_o && ready_i) got.push_back(parallel_o);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic s, input logic c, input logic r,
                       input logic [WIDTH-1:0] par, input logic vld, input logic emp,
                       input logic ovr, input logic [CNT_W-1:0] cnt);
        vec_t e;
        e.v = v; e.s = s; e.c = c; e.r = r;
        e.par = par; e.vld = vld; e.emp = emp; e.ovr = ovr; e.cnt = cnt;
        vecs.push_back(e);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic r);
        for (int i = 0; i < WIDTH; i++) step(1'b1, w[i], 1'b0, r);
    endtask

    // Reference model: collected bits in a queue, pending word + sticky flag.
    logic             m_bits[$];
    logic             m_pend;
    logic [WIDTH-1:0] m_word;
    logic             m_ovr;

    task automatic model_reset();
        m_bits.delete(); m_pend = 1'b0; m_word = '0; m_ovr = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic s, input logic c, input logic r);
        int w;
        if (c) begin
            m_bits.delete();
            m_ovr = 1'b0;
            if (m_pend && r) m_pend = 1'b0;
        end else if (v && m_bits.size() == WIDTH - 1) begin
            m_bits.push_back(s);
            w = 0;
            for (int i = 0; i < WIDTH; i++) w += int'(m_bits[i]) * (1 << i);
            m_bits.delete();
            if (m_pend && !r) m_ovr = 1'b1;
            else begin m_word = WIDTH'(w); m_pend = 1'b1; end
        end else begin
            if (v) m_bits.push_back(s);
            if (m_pend && r) m_pend = 1'b0;
        end
    endtask

    task automatic mstep(input string tag, input logic v, input logic s, input logic c,
                         input logic r);
        step(v, s, c, r);
        model_edge(v, s, c, r);
        chk_all(tag, m_word, m_pend, m_bits.size() == 0, m_ovr, CNT_W'(m_bits.size()));
    endtask

    initial begin
        logic [WIDTH-1:0] sent[$];
        logic [WIDTH-1:0] w;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            serial_i = 1'($urandom); valid_i = 1'($urandom);
            @(posedge clk); #1;
            chk_all("reset", '0, 1'b0, 1'b1, 1'b0, '0);
        end
        @(negedge clk);
        reset = 1'b1; valid_i = 1'b0; serial_i = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("post_reset", '0, 1'b0, 1'b1, 1'b0, '0);

        // Basic word 0,1,0,1 with ready high.
        add(1,0,0,1, 4'h0,0,0,0,2'd1); add(1,1,0,1, 4'h0,0,0,0,2'd2);
        add(1,0,0,1, 4'h0,0,0,0,2'd3); add(1,1,0,1, 4'hA,1,1,0,2'd0);
        add(0,0,0,1, 4'hA,0,1,0,2'd0);
        // Gapped 4'b1100.
        add(1,0,0,1, 4'hA,0,0,0,2'd1);
        add(0,1,0,1, 4'hA,0,0,0,2'd1); add(0,1,0,1, 4'hA,0,0,0,2'd1);
        add(1,0,0,1, 4'hA,0,0,0,2'd2);
        add(0,1,0,1, 4'hA,0,0,0,2'd2); add(0,0,0,1, 4'hA,0,0,0,2'd2);
        add(1,1,0,1, 4'hA,0,0,0,2'd3);
        add(0,0,0,1, 4'hA,0,0,0,2'd3); add(0,0,0,1, 4'hA,0,0,0,2'd3);
        add(1,1,0,1, 4'hC,1,1,0,2'd0);
        add(0,0,0,1, 4'hC,0,1,0,2'd0);
        // Backpressure: 4'hA then 4'h3 with ready low -> overrun.
        add(1,0,0,0, 4'hC,0,0,0,2'd1); add(1,1,0,0, 4'hC,0,0,0,2'd2);
        add(1,0,0,0, 4'hC,0,0,0,2'd3); add(1,1,0,0, 4'hA,1,1,0,2'd0);
        add(1,1,0,0, 4'hA,1,0,0,2'd1); add(1,1,0,0, 4'hA,1,0,0,2'd2);
        add(1,0,0,0, 4'hA,1,0,0,2'd3); add(1,0,0,0, 4'hA,1,1,1,2'd0);
        add(0,0,0,0, 4'hA,1,1,1,2'd0);
        add(0,0,0,1, 4'hA,0,1,1,2'd0);
        add(0,0,1,0, 4'hA,0,1,0,2'd0);
        // Back-to-back: 4'h5 stalls, ready rises with the last bit of 4'h9.
        add(1,1,0,0, 4'hA,0,0,0,2'd1); add(1,0,0,0, 4'hA,0,0,0,2'd2);
        add(1,1,0,0, 4'hA,0,0,0,2'd3); add(1,0,0,0, 4'h5,1,1,0,2'd0);
        add(1,1,0,0, 4'h5,1,0,0,2'd1); add(1,0,0,0, 4'h5,1,0,0,2'd2);
        add(1,0,0,0, 4'h5,1,0,0,2'd3); add(1,1,0,1, 4'h9,1,1,0,2'd0);
        add(0,0,0,1, 4'h9,0,1,0,2'd0);
        // clr_i leaves a pending word intact.
        add(1,1,0,0, 4'h9,0,0,0,2'd1); add(1,1,0,0, 4'h9,0,0,0,2'd2);
        add(1,1,0,0, 4'h9,0,0,0,2'd3); add(1,1,0,0, 4'hF,1,1,0,2'd0);
        add(1,1,1,0, 4'hF,1,1,0,2'd0);
        add(0,0,0,1, 4'hF,0,1,0,2'd0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].s, vecs[i].c, vecs[i].r);
            chk_all($sformatf("vec%0d", i), vecs[i].par, vecs[i].vld, vecs[i].emp,
                    vecs[i].ovr, vecs[i].cnt);
        end

        // Asynchronous reset between edges discards a partial word.
        step(1, 1, 0, 1); step(1, 0, 0, 1);
        chk("mid.count_before", int'(bit_count_o), 2);
        #2 reset = 1'b0;
        #1;
        chk_all("async_reset", '0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk); reset = 1'b1;
        // clr_i with valid_i: the bit is discarded.
        step(1, 1, 0, 1); step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        chk_all("clr_valid", '0, 1'b0, 1'b1, 1'b0, '0);
        send_word(4'h6, 1'b1);
        chk_all("word6", 4'h6, 1'b1, 1'b1, 1'b0, '0);
        step(0, 0, 0, 1);

        // Loopback: random words serialized LSB first with random gaps, ready high.
        got.delete();
        for (int k = 0; k < 5; k++) begin
            w = WIDTH'($urandom);
            sent.push_back(w);
            for (int i = 0; i < WIDTH; i++) begin
                repeat ($urandom_range(0, 2)) step(0, 1'($urandom), 0, 1);
                step(1, w[i], 0, 1);
            end
        end
        step(0, 0, 0, 1);
        chk("loop.count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk($sformatf("loop.word%0d", k), int'(got[k]), int'(sent[k]));

        // Randomized run against the model, starting from reset.
        @(negedge clk); reset = 1'b0; valid_i = 0; clr_i = 0; ready_i = 0;
        @(negedge clk); reset = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++)
            mstep("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Deserializer that is the receive-side counterpart of the team's 4-bit parallel-to-serial transmitter. It samples one serial bit per qualified clock, LSB first, and assembles WIDTH bits into a parallel word. The completed word is held in an output register behind a valid/ready handshake, with a sticky overrun flag. It sits at the far end of the serial link, or in a loopback with the transmitter, and feeds a parallel consumer.

Parameters:
WIDTH, 4, word width in bits; legal range 2 or more.
CNT_W, $clog2(WIDTH), width of the bit counter; derived, do not override.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
serial_i  input  1  serial data bit, LSB of each word first.
valid_i  input  1  serial_i is sampled only on edges where valid_i=1.
clr_i  input  1  synchronous clear of the partial word and overrun flag.
ready_i  input  1  consumer accepts parallel_o on an edge where valid_o=1 and ready_i=1.
parallel_o  output  WIDTH  assembled word (output holding register).
valid_o  output  1  parallel_o holds an unaccepted word.
empty_o  output  1  no bits of a partial word are collected (bit count = 0).
overrun_o  output  1  sticky; a completed word was dropped.
bit_count_o  output  CNT_W  number of bits collected in the current partial word.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - shift register = 0, bit count = 0, parallel_o = 0.
  - valid_o = 0, empty_o = 1, overrun_o = 0, bit_count_o = 0.
  - A partial word in progress is discarded.
- Shift:
  - On an edge with valid_i=1 and clr_i=0, serial_i is written into bit position bit_count of the shift register, and the count increments.
  - LSB is received first.
  - With valid_i=0, count and contents hold; gaps of any length are legal.
- Completion:
  - An edge accepting the WIDTH-th bit forms the word from the WIDTH-1 stored bits plus the current serial_i.
  - The bit count wraps to 0.
  - Latency: the word appears on parallel_o and valid_o=1 in the cycle after the edge that samples the last bit.
- Output register states:
  - EMPTY_OUT (valid_o=0) and FULL_OUT (valid_o=1).
  - EMPTY_OUT -> FULL_OUT on completion.
  - FULL_OUT -> EMPTY_OUT on an edge with ready_i=1 and no completion.
  - FULL_OUT stays FULL_OUT on an edge with ready_i=1 and a completion: the new word loads and valid_o stays 1 (back-to-back, no bubble).
  - FULL_OUT with ready_i=0: parallel_o is held stable.
- Overrun:
  - Triggered by a completion while valid_o=1 and ready_i=0.
  - The new word is discarded; the old word is kept.
  - overrun_o is set the next cycle and the bit count still wraps to 0.
  - overrun_o is cleared only by reset or clr_i.
- clr_i:
  - On an edge with clr_i=1: bit count = 0, shift register = 0, overrun_o = 0.
  - parallel_o and valid_o are unaffected; a pending word survives clr_i.
  - clr_i=1 together with valid_i=1: clr_i wins and the bit is discarded.
- empty_o = (bit count == 0).
  - empty_o is independent of valid_o; empty_o=1 with valid_o=1 is legal.
- ready_i while valid_o=0 is ignored.
- parallel_o changes only on completion-load or reset; it is never cleared by acceptance.

Test Plan:
1. Reset:
   - Stimulus: hold reset=0 for 2 cycles with random serial_i and valid_i.
   - Response: parallel_o=0, valid_o=0, empty_o=1, overrun_o=0, bit_count_o=0.
   - Stimulus: release reset.
   - Response: outputs hold until the first valid_i.
2. Basic word:
   - Stimulus: ready_i=1; send bits 0,1,0,1 on 4 consecutive valid_i cycles.
   - Response: bit_count_o steps 1,2,3,0; valid_o=1 for exactly one cycle, the cycle after the 4th bit; parallel_o=4'b1010.
3. Gapped input:
   - Stimulus: send the bits of 4'b1100 (0,0,1,1) with 2 idle valid_i=0 cycles between each bit.
   - Response: count holds during gaps, empty_o=0 mid-word, parallel_o=4'b1100 after the last bit.
4. Backpressure and overrun:
   - Stimulus: ready_i=0; send 4'hA, then 4'h3.
   - Response: parallel_o stays 4'hA with valid_o=1; overrun_o=1 the cycle after the 8th bit.
   - Stimulus: set ready_i=1 for one cycle.
   - Response: valid_o drops.
   - Stimulus: pulse clr_i.
   - Response: overrun_o=0.
5. Back-to-back:
   - Stimulus: ready_i=0 while word 4'h5 completes; raise ready_i on the same edge that the last bit of 4'h9 is sampled.
   - Response: valid_o stays 1, parallel_o=4'h9, overrun_o=0.
6. Mid-word reset and clear:
   - Stimulus: send 2 bits, assert reset=0 asynchronously between edges.
   - Response: bit_count_o=0 immediately.
   - Stimulus: send 2 bits, then clr_i=1 together with valid_i=1.
   - Response: bit_count_o=0.
   - Stimulus: send a full 4'h6.
   - Response: 4'h6 is received correctly; loopback against the transmitter with 5 random words matches exactly.
